posit_add_arbiter: RTL and testbench
====================================

POSIT_ADD_ARBITER -- requirements
Module: posit_add_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, posit word width.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter TAG_DEPTH, default 16, in-flight tag FIFO depth (power of 2, at least the adder latency).
REQ-004 Ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 Ports: rst_n  in  1  reset, synchronous, active-low.
REQ-006 Ports: req_valid  in  NREQ  per-requester operation request.
REQ-007 Ports: req_in1, req_in2  in  NREQ*N  per-requester operands, requester i at bits [i*N +: N].
REQ-008 Ports: req_ready  out  NREQ  one-hot grant, operation accepted this cycle.
REQ-009 Ports: add_in1, add_in2  out  N  operands to the shared positadd.
REQ-010 Ports: add_start  out  1  issue strobe to positadd.
REQ-011 Ports: add_result  in  N;  add_inf  in  1;  add_zero  in  1;  add_done  in  1  positadd outputs.
REQ-012 Ports: resp_valid  out  NREQ  one-hot result strobe.
REQ-013 Ports: resp_result  out  N;  resp_inf  out  1;  resp_zero  out  1  result, shared by all requesters.
REQ-014 Ports: busy  out  1  tag FIFO non-empty.
REQ-015 Ports: err  out  1  sticky orphan-done flag.

Function
REQ-016 Arbitration SHALL be round-robin: search starts at index rr_ptr; on a grant to i, rr_ptr becomes (i+1) mod NREQ.
REQ-017 Grant conditions: at most one grant per cycle, and only when tag FIFO count < TAG_DEPTH.
- When FIFO is full: req_ready SHALL be all-zero and rr_ptr SHALL hold.
REQ-018 Issue: in the cycle after a grant to i, the block SHALL register add_start=1 with add_in1/add_in2 = requester i operands sampled at the grant, and push tag i.
- Issue latency: 1 cycle.
REQ-019 Outside issue cycles, add_start SHALL be 0 and add_in1/add_in2 SHALL hold their last values.
REQ-020 Completion: on add_done=1 with the FIFO non-empty, the block SHALL pop tag t.
- In the next cycle it SHALL present resp_valid = one-hot(t) with resp_result/resp_inf/resp_zero = registered add_result/add_inf/add_zero.
- Completion latency: 1 cycle.
REQ-021 resp_valid SHALL be a single-cycle pulse; there is no response backpressure.
REQ-022 Simultaneous push and pop in one cycle SHALL leave the count unchanged; both pointers SHALL advance and wrap mod TAG_DEPTH.
REQ-023 add_done with an empty FIFO SHALL set err (sticky until reset), SHALL produce no resp_valid, and SHALL not change the pointers.
REQ-024 Results SHALL be returned strictly in issue order; positadd is in-order.
REQ-025 busy SHALL be 1 iff the FIFO count is non-zero.

Reset
REQ-026 While rst_n=0 at a clock edge, the block SHALL clear:
- rr_ptr=0, FIFO pointers and count=0;
- add_start=0, add_in1=add_in2=0;
- req_ready=0, resp_valid=0, resp_result=0, resp_inf=0, resp_zero=0, err=0, busy=0.
REQ-027 Reset mid-operation SHALL discard all in-flight tags; add_done pulses after reset release for pre-reset operations SHALL set err.

Configuration
REQ-028 With POSIT_ARB_STATS_EN defined, the block SHALL add outputs issue_cnt (32-bit) and stall_cnt (32-bit):
- issue_cnt increments per grant;
- stall_cnt increments per cycle with any req_valid and no grant;
- both saturate at all-ones and reset to 0.
REQ-029 Without POSIT_ARB_STATS_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-030 Shared package posit_arb_pkg SHALL hold the default N, NREQ and TAG_DEPTH constants and the tag typedef (width $clog2(NREQ)).
REQ-031 Tag FIFO SHALL be sub-module posit_tag_fifo (push, pop, data, count, full, empty); the arbiter and response register are top-level.

Verification
REQ-032 Single request: r0 valid, in1=in2=0x40000000, model returns done with 0x48000000 after 5 cycles -> req_ready[0] one cycle, add_start one cycle later, resp_valid=0001, resp_result=0x48000000.
REQ-033 All four valid continuously, 8 cycles -> grants r0,r1,r2,r3,r0,r1,r2,r3 and responses in the same order.
REQ-034 TAG_DEPTH=4, model never asserts done -> exactly 4 grants, then req_ready=0 and busy=1; one done -> exactly one further grant.
REQ-035 Zero/NaR propagation: r2 sends 0+0 (done, add_zero=1) -> resp_valid=0100, resp_zero=1; r3 sends 0x80000000 (add_inf=1) -> resp_inf=1.
REQ-036 add_done pulse with no request outstanding -> err=1, no resp_valid; rst_n=0 for 1 cycle -> err=0 and all outputs at reset values.
REQ-037 With POSIT_ARB_STATS_EN: 10 grants and 3 full-stall cycles -> issue_cnt=10, stall_cnt=3.

Source files
------------

// File: rtl/posit_arb_pkg.sv
// posit_arb_pkg
//   Shared constants and helpers for the posit adder front-end arbiter.
//   DEF_N / DEF_NREQ / DEF_TAG_DEPTH are the default parameter values of
//   posit_add_arbiter. tag_t is the requester-index tag kept in the in-flight
//   FIFO for the default requester count.
package posit_arb_pkg;

  localparam int DEF_N         = 32;
  localparam int DEF_NREQ      = 4;
  localparam int DEF_TAG_DEPTH = 16;

  localparam int TAG_W = $clog2(DEF_NREQ);

  typedef logic [TAG_W-1:0] tag_t;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Requester visited at step k of a round-robin sweep starting at base.
  function automatic int rr_idx(input int base, input int k, input int n);
    int s;
    s = base + k;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/posit_tag_fifo.sv
// posit_tag_fifo
//   In-flight tag queue: one entry per operation issued to the shared adder,
//   popped when the adder reports completion. Pointers wrap mod DEPTH
//   (DEPTH must be a power of two, at least 2).
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   push, din   write din (ignored when full)
//   pop, dout   remove head entry (ignored when empty); dout shows head
//   count       number of stored entries (0..DEPTH)
//   full, empty status flags derived from count
module posit_tag_fifo
  import posit_arb_pkg::*;
#(
  parameter int DEPTH = DEF_TAG_DEPTH,
  parameter int W     = TAG_W,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = idx_w(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Qualify requests against the current occupancy.
  always_comb begin
    push_ok_s = push && (count_r != CW'(DEPTH));
    pop_ok_s  = pop && (count_r != {CW{1'b0}});
  end

  // Pointer and occupancy bookkeeping; push+pop together keeps the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Tag storage; contents are only meaningful between push and pop.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/posit_add_arbiter.sv
// posit_add_arbiter
//   Round-robin front end that shares one pipelined, in-order posit adder
//   between NREQ requesters. A granted operation is issued one cycle later
//   and its requester index is queued as a tag; each adder completion pops
//   a tag and returns the result to that requester one cycle later.
//   A completion with no outstanding tag sets the sticky err flag.
// Optional feature: define POSIT_ARB_STATS_EN to add saturating 32-bit
//   issue_cnt (grants) and stall_cnt (cycles with a request but no grant).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid[NREQ]            per-requester request
//   req_in1/req_in2[NREQ*N]    operands, requester i at [i*N +: N]
//   req_ready[NREQ]            one-hot grant (accepted this cycle)
//   add_in1/add_in2/add_start  issue to the adder
//   add_result/inf/zero/done   adder completion
//   resp_valid[NREQ]           one-hot result pulse
//   resp_result/inf/zero       shared result bus
//   busy                       operations in flight
//   err                        sticky orphan-completion flag
module posit_add_arbiter
  import posit_arb_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int NREQ      = DEF_NREQ,
  parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_in1,
  input  logic [NREQ*N-1:0] req_in2,
  output logic [NREQ-1:0]   req_ready,
  output logic [N-1:0]      add_in1,
  output logic [N-1:0]      add_in2,
  output logic              add_start,
  input  logic [N-1:0]      add_result,
  input  logic              add_inf,
  input  logic              add_zero,
  input  logic              add_done,
  output logic [NREQ-1:0]   resp_valid,
  output logic [N-1:0]      resp_result,
  output logic              resp_inf,
  output logic              resp_zero,
  output logic              busy,
  output logic              err
`ifdef POSIT_ARB_STATS_EN
  ,
  output logic [31:0]       issue_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int TW = idx_w(NREQ);
  localparam int CW = $clog2(TAG_DEPTH) + 1;

  logic [TW-1:0]   rr_ptr_r;
  logic [TW-1:0]   cand_s;
  logic [TW-1:0]   gidx_s;
  logic            gfound_s;
  logic            can_grant_s;
  logic [NREQ-1:0] grant_s;
  logic [N-1:0]    op1_s;
  logic [N-1:0]    op2_s;
  logic [NREQ-1:0] resp_onehot_s;
  logic            pop_s;
  logic            orphan_s;
  logic [TW-1:0]   fifo_dout_s;
  logic [CW-1:0]   fifo_count_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;

  // Grants are blocked in reset and whenever every tag slot is taken
  // (a pop in the same cycle does not free a slot until the next cycle).
  assign can_grant_s = rst_n && !fifo_full_s;

  // Round-robin search: first valid requester at or after rr_ptr.
  always_comb begin
    gfound_s = 1'b0;
    gidx_s   = {TW{1'b0}};
    cand_s   = {TW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      cand_s = TW'(rr_idx(int'(rr_ptr_r), k, NREQ));
      if (!gfound_s && req_valid[cand_s] && can_grant_s) begin
        gfound_s = 1'b1;
        gidx_s   = cand_s;
      end else begin
        gidx_s = gidx_s;
      end
    end
  end

  // One-hot grant vector and operand selection for the winner.
  always_comb begin
    grant_s = {NREQ{1'b0}};
    op1_s   = {N{1'b0}};
    op2_s   = {N{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (gfound_s && (gidx_s == TW'(i))) begin
        grant_s[i] = 1'b1;
        op1_s      = req_in1[i*N +: N];
        op2_s      = req_in2[i*N +: N];
      end else begin
        grant_s[i] = 1'b0;
      end
    end
  end

  assign req_ready = grant_s;

  // Round-robin pointer and issue registers; operands hold between issues.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r  <= {TW{1'b0}};
      add_start <= 1'b0;
      add_in1   <= {N{1'b0}};
      add_in2   <= {N{1'b0}};
    end else begin
      add_start <= gfound_s;
      if (gfound_s) begin
        rr_ptr_r <= (gidx_s == TW'(NREQ - 1)) ? {TW{1'b0}} : (gidx_s + TW'(1));
        add_in1  <= op1_s;
        add_in2  <= op2_s;
      end
    end
  end

  // Completion bookkeeping: a done either retires the oldest tag or is an orphan.
  always_comb begin
    pop_s    = add_done && !fifo_empty_s;
    orphan_s = add_done && fifo_empty_s;
  end

  posit_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (TW),
    .CW    (CW)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (gfound_s),
    .pop   (pop_s),
    .din   (gidx_s),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Decode the retiring tag into the response strobe.
  always_comb begin
    resp_onehot_s = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (pop_s && (fifo_dout_s == TW'(i))) begin
        resp_onehot_s[i] = 1'b1;
      end else begin
        resp_onehot_s[i] = 1'b0;
      end
    end
  end

  // Response register: one-cycle strobe, result bus holds between responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid  <= {NREQ{1'b0}};
      resp_result <= {N{1'b0}};
      resp_inf    <= 1'b0;
      resp_zero   <= 1'b0;
      err         <= 1'b0;
    end else begin
      resp_valid <= resp_onehot_s;
      err        <= err | orphan_s;
      if (pop_s) begin
        resp_result <= add_result;
        resp_inf    <= add_inf;
        resp_zero   <= add_zero;
      end
    end
  end

  assign busy = (fifo_count_s != {CW{1'b0}});

`ifdef POSIT_ARB_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (gfound_s && (issue_cnt != 32'hFFFF_FFFF)) begin
        issue_cnt <= issue_cnt + 32'd1;
      end
      if ((|req_valid) && !gfound_s && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_posit_add_arbiter.sv
// Bench for posit_add_arbiter (NREQ=4, TAG_DEPTH=4) with a behavioural
// in-order adder. Expected responses are queued when a grant is expected
// and checked when resp_valid fires.
module tb_posit_add_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int TD   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_in1;
  logic [NREQ*N-1:0] req_in2;
  logic [NREQ-1:0]   req_ready;
  logic [N-1:0]      add_in1;
  logic [N-1:0]      add_in2;
  logic              add_start;
  logic [N-1:0]      add_result;
  logic              add_inf;
  logic              add_zero;
  logic              add_done;
  logic [NREQ-1:0]   resp_valid;
  logic [N-1:0]      resp_result;
  logic              resp_inf;
  logic              resp_zero;
  logic              busy;
  logic              err;
`ifdef POSIT_ARB_STATS_EN
  logic [31:0]       issue_cnt;
  logic [31:0]       stall_cnt;
`endif

  always #5 clk = ~clk;

  posit_add_arbiter #(.N(N), .NREQ(NREQ), .TAG_DEPTH(TD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_in1     (req_in1),
    .req_in2     (req_in2),
    .req_ready   (req_ready),
    .add_in1     (add_in1),
    .add_in2     (add_in2),
    .add_start   (add_start),
    .add_result  (add_result),
    .add_inf     (add_inf),
    .add_zero    (add_zero),
    .add_done    (add_done),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .resp_inf    (resp_inf),
    .resp_zero   (resp_zero),
    .busy        (busy),
    .err         (err)
`ifdef POSIT_ARB_STATS_EN
    ,
    .issue_cnt   (issue_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  logic [31:0] op1 [NREQ];
  logic [31:0] op2 [NREQ];

  always_comb begin
    req_in1 = '0;
    req_in2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_in1[i*N +: N] = op1[i];
      req_in2[i*N +: N] = op2[i];
    end
  end

  typedef struct { logic [3:0] vld; logic [31:0] res; logic inf; logic zero; } exp_t;
  typedef struct { logic [31:0] res; logic inf; logic zero; int due; } mq_t;

  exp_t sb [$];
  mq_t  mq [$];

  int chk_cnt = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int exp_issue = 0;
  int exp_stall = 0;
  int cyc = 0;
  int lat = 5;
  bit hold = 1'b0;
  bit one_shot = 1'b0;
  bit force_done = 1'b0;

  // Stand-in adder: {inf, zero, result}. NaR dominates, 0+0 is zero,
  // 1.0+1.0 = 2.0, anything else is an arbitrary but deterministic mix.
  function automatic logic [33:0] fake_add(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h8000_0000 || b == 32'h8000_0000) return {1'b1, 1'b0, 32'h8000_0000};
    else if (a == 32'h0 && b == 32'h0) return {1'b0, 1'b1, 32'h0};
    else if (a == 32'h4000_0000 && b == 32'h4000_0000) return {2'b00, 32'h4800_0000};
    else return {2'b00, a ^ {b[15:0], b[31:16]}};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus: drive req_valid, check the grant just before the edge.
  task automatic step(input logic [3:0] v, input logic [3:0] exp_rdy, input string tag);
    int idx;
    logic [33:0] r;
    @(negedge clk);
    req_valid = v;
    #4;
    check(tag, 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0000) begin
      idx = 0;
      for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) idx = i;
      r = fake_add(op1[idx], op2[idx]);
      sb.push_back('{exp_rdy, r[31:0], r[33], r[32]});
      exp_issue++;
    end else if (v != 4'b0000) begin
      exp_stall++;
    end
  endtask

  // Reset for exactly one rising edge, requests asserted to show they are masked.
  task automatic do_reset(input bit chk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = 4'hF;
    sb.delete();
    exp_issue = 0;
    exp_stall = 0;
    @(negedge clk);
    #1;
    if (chk) begin
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_add_start", 32'(add_start), 32'h0);
      check("rst_add_in1", add_in1, 32'h0);
      check("rst_add_in2", add_in2, 32'h0);
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_resp_result", resp_result, 32'h0);
      check("rst_resp_inf", 32'(resp_inf), 32'h0);
      check("rst_resp_zero", 32'(resp_zero), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
    end
    req_valid = 4'h0;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 80; i++) begin
      if (sb.size() == 0 && mq.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    #1;
    check({"drain_", tag}, 32'(sb.size()), 32'h0);
  endtask

  // Behavioural in-order adder: fixed latency, optional hold / single release.
  initial begin
    logic [33:0] r;
    add_done = 1'b0;
    add_result = 32'h0;
    add_inf = 1'b0;
    add_zero = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      add_done = 1'b0;
      if (force_done) begin
        force_done = 1'b0;
        add_done = 1'b1;
        add_result = 32'h1234_5678;
        add_inf = 1'b0;
        add_zero = 1'b0;
      end else if (mq.size() != 0 && ((!hold && mq[0].due <= cyc) || (hold && one_shot))) begin
        one_shot = 1'b0;
        add_done = 1'b1;
        add_result = mq[0].res;
        add_inf = mq[0].inf;
        add_zero = mq[0].zero;
        void'(mq.pop_front());
      end
      if (add_start === 1'b1) begin
        r = fake_add(add_in1, add_in2);
        mq.push_back('{r[31:0], r[33], r[32], cyc + lat});
      end
    end
  end

  // Response monitor: every strobe must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid !== 4'b0000) begin
        if (sb.size() == 0) begin
          check("resp_unexpected", 32'(resp_valid), 32'h0);
        end else begin
          e = sb.pop_front();
          check("resp_valid", 32'(resp_valid), 32'(e.vld));
          check("resp_result", resp_result, e.res);
          check("resp_inf", 32'(resp_inf), 32'(e.inf));
          check("resp_zero", 32'(resp_zero), 32'(e.zero));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 4'h0;
    for (int i = 0; i < NREQ; i++) begin
      op1[i] = 32'h0;
      op2[i] = 32'h0;
    end
    do_reset(1'b1);

    // Single request, 1.0 + 1.0
    op1[0] = 32'h4000_0000;
    op2[0] = 32'h4000_0000;
    lat = 5;
    step(4'b0001, 4'b0001, "single_grant");
    step(4'b0000, 4'b0000, "single_idle");
    check("issue_start", 32'(add_start), 32'h1);
    check("issue_in1", add_in1, 32'h4000_0000);
    check("issue_in2", add_in2, 32'h4000_0000);
    check("busy_inflight", 32'(busy), 32'h1);
    @(negedge clk);
    #1;
    check("start_pulse", 32'(add_start), 32'h0);
    check("in1_hold", add_in1, 32'h4000_0000);
    wait_drain("single");
    check("busy_idle", 32'(busy), 32'h0);

    // Four continuous requesters, round robin
    do_reset(1'b0);
    lat = 1;
    for (int i = 0; i < NREQ; i++) begin
      op1[i] = 32'h1111_0000 * (i + 1) + 32'(i);
      op2[i] = 32'h0101_2020 + 32'(i * 7);
    end
    for (int i = 0; i < 8; i++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (i % NREQ);
      step(4'hF, oh, "rr_grant");
    end
    step(4'h0, 4'h0, "rr_idle");
    wait_drain("rr");

    // Tag FIFO full: adder holds all completions
    do_reset(1'b0);
    lat = 5;
    hold = 1'b1;
    step(4'hF, 4'b0001, "full_g0");
    step(4'hF, 4'b0010, "full_g1");
    step(4'hF, 4'b0100, "full_g2");
    step(4'hF, 4'b1000, "full_g3");
    step(4'hF, 4'b0000, "full_stall0");
    step(4'hF, 4'b0000, "full_stall1");
    check("full_busy", 32'(busy), 32'h1);
    one_shot = 1'b1;
    step(4'hF, 4'b0000, "full_stall_pop");
    step(4'hF, 4'b0001, "full_regrant");
    step(4'hF, 4'b0000, "full_stall2");
    step(4'h0, 4'b0000, "full_idle");
`ifdef POSIT_ARB_STATS_EN
    check("issue_cnt", issue_cnt, 32'(exp_issue));
    check("stall_cnt", stall_cnt, 32'(exp_stall));
`endif
    hold = 1'b0;
    wait_drain("full");

    // Zero and NaR propagation
    op1[2] = 32'h0;
    op2[2] = 32'h0;
    op1[3] = 32'h8000_0000;
    op2[3] = 32'h3000_0000;
    step(4'b0100, 4'b0100, "zero_grant");
    step(4'b1000, 4'b1000, "nar_grant");
    step(4'b0000, 4'b0000, "special_idle");
    wait_drain("special");

    // Orphan completion sets err; reset clears it
    force_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("orphan_err", 32'(err), 32'h1);
    check("orphan_no_resp", 32'(resp_valid), 32'h0);
    check("orphan_busy", 32'(busy), 32'h0);
    @(negedge clk);
    #1;
    check("orphan_err_sticky", 32'(err), 32'h1);
    do_reset(1'b1);

    // Reset with an operation in flight: its late completion is an orphan
    lat = 5;
    op1[1] = 32'h3C00_0000;
    op2[1] = 32'h4400_0000;
    step(4'b0010, 4'b0010, "midrst_grant");
    step(4'b0000, 4'b0000, "midrst_idle");
    do_reset(1'b0);
    check("midrst_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (err === 1'b1) break;
    end
    #1;
    check("midrst_err", 32'(err), 32'h1);
    @(negedge clk);
    @(negedge clk);
    op1[0] = 32'h5000_0000;
    op2[0] = 32'h2000_0001;
    step(4'hF, 4'b0001, "midrst_rr_reset");
    step(4'h0, 4'b0000, "midrst_idle2");
    wait_drain("midrst");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
